// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared note, colour and FSM types for the note history plot
package music_pkg;

   typedef logic [3:0] note_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      logic  valid;
      note_t note;
   } entry_t;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HOLD,
      ST_CLEAR
   } state_t;

   localparam int PALETTE_N = 12;

   // Pitch-class colours, C first
   localparam rgb_t NOTE_PALETTE [PALETTE_N] = '{
      '{8'd90,  8'd222, 8'd0},
      '{8'd219, 8'd221, 8'd0},
      '{8'd219, 8'd95,  8'd0},
      '{8'd188, 8'd0,   8'd0},
      '{8'd233, 8'd0,   8'd88},
      '{8'd233, 8'd0,   8'd226},
      '{8'd111, 8'd0,   8'd231},
      '{8'd0,   8'd0,   8'd216},
      '{8'd0,   8'd89,  8'd233},
      '{8'd0,   8'd227, 8'd233},
      '{8'd0,   8'd230, 8'd108},
      '{8'd0,   8'd211, 8'd0}
   };

   localparam rgb_t CURSOR_RGB = '{8'd255, 8'd255, 8'd255};

endpackage

// File: rtl/history_ram.sv
// rtl/history_ram.sv - column history register file, async read, one-entry-per-cycle clear
module history_ram
   import music_pkg::*;
#(
   parameter int COLS = 136,
   parameter int AW   = $clog2(COLS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata,
   input  logic          clr,
   input  logic [AW-1:0] clr_addr
);

   entry_t mem [COLS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < COLS; i++) mem[i] <= '0;
      end else if (clr) begin
         mem[clr_addr] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/note_history_plot.sv
// rtl/note_history_plot.sv - records sounding pitch class per column and renders it as bars
module note_history_plot
   import music_pkg::*;
#(
   parameter int NOTES          = 12,
   parameter int COLS           = 136,
   parameter int COL_W_LOG2     = 2,
   parameter int X_ORIGIN       = 65,
   parameter int Y_ORIGIN       = 30,
   parameter int ROW_H          = 35,
   parameter int BAR_PAD        = 8,
   parameter int FRAMES_PER_COL = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic       frame_start,
   input  logic       note_valid,
   input  logic [3:0] note,
   input  logic       mode,
   input  logic       hold,
   input  logic       clear,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b,
   output logic       hit
);

   localparam int AW = $clog2(COLS);
   localparam int FW = (FRAMES_PER_COL > 1) ? $clog2(FRAMES_PER_COL) : 1;
   localparam logic [AW-1:0] LAST_COL   = AW'(COLS - 1);
   localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES_PER_COL - 1);
   localparam logic [10:0]   PLOT_W     = 11'(COLS << COL_W_LOG2);
   localparam logic [9:0]    PLOT_H     = 10'(NOTES * ROW_H);

   state_t        state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] clr_idx;
   logic [FW-1:0] fcnt;
   entry_t        pend;

   logic   accept;
   logic   running;
   logic   commit;
   entry_t commit_entry;
   entry_t rd_entry;

   assign accept       = note_valid && (note < 4'(NOTES));
   assign running      = (state == ST_RUN) && !hold && !clear;
   assign commit       = running && frame_start && (fcnt == LAST_FRAME);
   // A note arriving on the commit cycle lands in the committed column
   assign commit_entry = accept ? {1'b1, note} : pend;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_RUN;
         wr_ptr  <= '0;
         clr_idx <= '0;
         fcnt    <= '0;
         pend    <= '0;
      end else if (clear) begin
         state   <= ST_CLEAR;
         wr_ptr  <= '0;
         clr_idx <= '0;
         fcnt    <= '0;
         pend    <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (hold) begin
                  state <= ST_HOLD;
               end else if (commit) begin
                  fcnt   <= '0;
                  pend   <= '0;
                  wr_ptr <= (wr_ptr == LAST_COL) ? '0 : wr_ptr + 1'b1;
               end else begin
                  if (frame_start) fcnt <= fcnt + 1'b1;
                  if (accept)      pend <= {1'b1, note};
               end
            end
            ST_HOLD: begin
               if (!hold) state <= ST_RUN;
            end
            ST_CLEAR: begin
               if (clr_idx == LAST_COL) begin
                  clr_idx <= '0;
                  state   <= hold ? ST_HOLD : ST_RUN;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   logic [10:0]   xo;
   logic [9:0]    yo;
   logic          in_plot;
   logic [AW-1:0] col;
   logic [AW:0]   idx_sum;
   logic [AW-1:0] rd_addr;
   logic          bar;
   logic          cursor;
   rgb_t          bar_rgb;
   rgb_t          pix_rgb;
   logic          pix_hit;

   history_ram #(.COLS(COLS)) u_ram (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (commit),
      .waddr    (wr_ptr),
      .wdata    (commit_entry),
      .raddr    (rd_addr),
      .rdata    (rd_entry),
      .clr      (state == ST_CLEAR),
      .clr_addr (clr_idx)
   );

   always_comb begin
      xo      = {1'b0, x} - 11'(X_ORIGIN);
      yo      = {1'b0, y} - 10'(Y_ORIGIN);
      in_plot = (x >= 10'(X_ORIGIN)) && (xo < PLOT_W) &&
                (y >= 9'(Y_ORIGIN))  && (yo < PLOT_H);
      col     = AW'(xo >> COL_W_LOG2);
      // Scroll mode: oldest column (at wr_ptr) is drawn leftmost
      idx_sum = {1'b0, wr_ptr} + {1'b0, col};
      if (!mode)                          rd_addr = col;
      else if (idx_sum >= (AW+1)'(COLS))  rd_addr = AW'(idx_sum - (AW+1)'(COLS));
      else                                rd_addr = idx_sum[AW-1:0];

      bar     = 1'b0;
      bar_rgb = '0;
      for (int i = 0; i < NOTES; i++) begin
         if (rd_entry.valid && (rd_entry.note == 4'(i)) &&
             ({1'b0, y} >= 10'(Y_ORIGIN + i * ROW_H + BAR_PAD)) &&
             ({1'b0, y} <  10'(Y_ORIGIN + (i + 1) * ROW_H - BAR_PAD))) begin
            bar     = 1'b1;
            bar_rgb = NOTE_PALETTE[i];
         end
      end

      cursor  = !mode && (col == wr_ptr);
      pix_hit = (state != ST_CLEAR) && in_plot && (cursor || bar);
      if (!pix_hit)    pix_rgb = '0;
      else if (cursor) pix_rgb = CURSOR_RGB;
      else             pix_rgb = bar_rgb;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r   <= '0;
         g   <= '0;
         b   <= '0;
         hit <= 1'b0;
      end else begin
         r   <= pix_rgb.r;
         g   <= pix_rgb.g;
         b   <= pix_rgb.b;
         hit <= pix_hit;
      end
   end

endmodule
